xip_prefetch_buffer: RTL and testbench



---
 rtl/xip_prefetch_buffer.sv | 148 ++++++++++++++
 tb/tb_xip_prefetch_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/xip_prefetch_buffer.sv
// Sequential instruction prefetch buffer between the CPU instruction-side
// AHB-Lite bus and the QSPI XIP controller. Sequential fetches that hit the
// head of a small word FIFO complete with zero wait states. A single-word
// master port refills the FIFO ahead of demand. A non-sequential fetch
// flushes the FIFO and turns into a demand read.
module xip_prefetch_buffer #(
  parameter int DEPTH         = 4,   // FIFO depth in words, power of 2, 2..16
  parameter int PF_BOUND_LOG2 = 10   // prefetch stays inside this aligned region
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        pf_en,
  input  logic        S_HSEL,
  input  logic [31:0] S_HADDR,
  input  logic [1:0]  S_HTRANS,
  input  logic        S_HWRITE,
  input  logic        S_HREADY,
  output logic        S_HREADYOUT,
  output logic [31:0] S_HRDATA,
  output logic        M_HSEL,
  output logic [31:0] M_HADDR,
  output logic [1:0]  M_HTRANS,
  output logic        M_HWRITE,
  input  logic        M_HREADY,
  input  logic [31:0] M_HRDATA
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {M_IDLE, M_ADDR, M_DATA} m_state_t;

  m_state_t        m_state, m_state_nxt;
  logic            p_valid;        // a slave read is in its data phase
  logic [31:0]     p_addr;         // word-aligned address of that read
  logic [31:0]     head_addr;      // address of the FIFO head word
  logic [31:0]     nf_addr;        // next address the master port fetches
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            discard;        // in-flight fetch belongs to a flushed stream
  logic            stream_valid;   // head/nf describe a real fetch stream
  logic [31:0]     mem [DEPTH];

  logic inflight, hit, wait_rd, miss, accept, beat, push, pf_ok, demand, issue;
  logic addr_phase;

  // The byte-lane bits and HTRANS[0] carry no information for this slave.
  logic unused_bits;
  assign unused_bits = ^{S_HADDR[1:0], S_HTRANS[0]};

  // Slave-side classification of the pending read and master issue decision.
  always_comb begin
    inflight = (m_state != M_IDLE);
    accept   = S_HSEL && S_HTRANS[1] && S_HREADY;
    hit      = p_valid && (count != '0) && (head_addr == p_addr);
    // With count==0 an undiscarded in-flight fetch is always for head_addr,
    // and in M_IDLE a demand for head_addr is about to be issued.
    wait_rd  = p_valid && (count == '0) && stream_valid && (head_addr == p_addr)
               && !(inflight && discard);
    miss     = p_valid && !hit && !wait_rd;
    beat     = (m_state == M_DATA) && M_HREADY;
    // Data landing in the miss-detect cycle belongs to the old stream.
    push     = beat && !discard && !miss;
    demand   = p_valid && (count == '0);
    pf_ok    = pf_en && stream_valid &&
               (nf_addr[31:PF_BOUND_LOG2] == head_addr[31:PF_BOUND_LOG2]);
    issue    = (m_state == M_IDLE) && !miss && (count < CW'(DEPTH)) && (demand || pf_ok);
  end

  // Master FSM next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    m_state_nxt = m_state;
    unique case (m_state)
      M_IDLE: if (issue)    m_state_nxt = M_ADDR;
      M_ADDR: if (M_HREADY) m_state_nxt = M_DATA;
      M_DATA: if (M_HREADY) m_state_nxt = M_IDLE;
      default:              m_state_nxt = M_IDLE;
    endcase
  end

  // Bus outputs; the master request drops as soon as reset is asserted.
  always_comb begin
    addr_phase  = (m_state == M_ADDR) && !HRESET;
    M_HSEL      = addr_phase;
    M_HTRANS    = addr_phase ? 2'b10 : 2'b00;
    M_HADDR     = addr_phase ? nf_addr : 32'd0;
    M_HWRITE    = 1'b0;
    S_HREADYOUT = !(p_valid && !hit);
    S_HRDATA    = hit ? mem[rd_ptr] : 32'd0;
  end

  // Master FSM state register.
  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (HRESET) m_state <= M_IDLE;
    else        m_state <= m_state_nxt;
  end

  // Pending slave read, FIFO bookkeeping, flush and fetch address tracking.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      p_valid      <= 1'b0;
      p_addr       <= 32'd0;
      head_addr    <= 32'd0;
      nf_addr      <= 32'd0;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      discard      <= 1'b0;
      stream_valid <= 1'b0;
    end else begin
      if (accept) begin
        p_valid <= !S_HWRITE;
        p_addr  <= {S_HADDR[31:2], 2'b00};
      end else if (hit) begin
        p_valid <= 1'b0;
      end

      if (miss) begin
        count        <= '0;
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        head_addr    <= p_addr;
        nf_addr      <= p_addr;
        stream_valid <= 1'b1;
        discard      <= inflight && !beat;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (hit) begin
          rd_ptr    <= rd_ptr + PW'(1);
          head_addr <= head_addr + 32'd4;
        end
        if (push && !hit)      count <= count + CW'(1);
        else if (!push && hit) count <= count - CW'(1);
        if ((m_state == M_ADDR) && M_HREADY) nf_addr <= nf_addr + 32'd4;
        if (beat) discard <= 1'b0;
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge HCLK) begin
    // NOTE: storage is not reset; count and pointers define which words are valid.
    if (push) mem[wr_ptr] <= M_HRDATA;
  end

endmodule

// File: tb/tb_xip_prefetch_buffer.sv
// Directed bench for xip_prefetch_buffer: a behavioural XIP slave with a
// configurable wait count logs every master address phase, and a linear
// sequence of CPU reads/writes checks data, latency and fetch order.
module tb_xip_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pf_en;
  logic        s_hsel;
  logic [31:0] s_haddr;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  wire         s_hready;
  logic        s_hreadyout;
  logic [31:0] s_hrdata;
  logic        m_hsel;
  logic [31:0] m_haddr;
  logic [1:0]  m_htrans;
  logic        m_hwrite;
  logic        m_hready = 1'b1;
  logic [31:0] m_hrdata = 32'd0;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] issued[$];
  int          xip_wait = 20;
  logic        dp_active = 1'b0;
  logic [31:0] dp_addr = 32'd0;
  int          dp_wait = 0;

  always #5 clk = ~clk;

  // Single-slave system: the bus HREADY is this slave's HREADYOUT.
  assign s_hready = s_hreadyout;

  xip_prefetch_buffer #(.DEPTH(4), .PF_BOUND_LOG2(10)) dut (
    .HCLK(clk), .HRESET(rst), .pf_en(pf_en),
    .S_HSEL(s_hsel), .S_HADDR(s_haddr), .S_HTRANS(s_htrans), .S_HWRITE(s_hwrite),
    .S_HREADY(s_hready), .S_HREADYOUT(s_hreadyout), .S_HRDATA(s_hrdata),
    .M_HSEL(m_hsel), .M_HADDR(m_haddr), .M_HTRANS(m_htrans), .M_HWRITE(m_hwrite),
    .M_HREADY(m_hready), .M_HRDATA(m_hrdata)
  );

  function automatic logic [31:0] xip_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  function automatic logic [31:0] q_at(input int i);
    if (i < issued.size()) return issued[i];
    return 32'hxxxx_xxxx;
  endfunction

  // Behavioural XIP slave, evaluated mid-cycle: drives HREADY/HRDATA for the
  // coming edge and logs accepted address phases.
  always @(negedge clk) begin
    if (rst) begin
      dp_active = 1'b0;
      m_hready  = 1'b1;
      m_hrdata  = 32'd0;
    end else if (dp_active && dp_wait > 0) begin
      m_hready = 1'b0;
      m_hrdata = 32'hBAD0_BAD0;
      dp_wait  = dp_wait - 1;
    end else begin
      m_hready = 1'b1;
      m_hrdata = 32'hBAD0_BAD0;
      if (dp_active) begin
        m_hrdata  = xip_word(dp_addr);
        dp_active = 1'b0;
      end
      if (m_htrans == 2'b10) begin
        dp_active = 1'b1;
        dp_addr   = m_haddr;
        dp_wait   = xip_wait;
        issued.push_back(m_haddr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One CPU read: address phase, then wait (bounded) for HREADYOUT.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int w);
    @(negedge clk);
    s_hsel = 1'b1; s_htrans = 2'b10; s_haddr = a; s_hwrite = 1'b0;
    @(negedge clk);
    s_hsel = 1'b0; s_htrans = 2'b00;
    w = 0;
    while (!s_hreadyout && w < 500) begin
      @(negedge clk);
      w++;
    end
    d = s_hrdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int          w;
    int          mark;

    rst = 1'b1; pf_en = 1'b1;
    s_hsel = 1'b0; s_haddr = 32'd0; s_htrans = 2'b00; s_hwrite = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state and no master activity while idle.
    wait_cyc(8);
    check("rst_hreadyout", 32'(s_hreadyout), 32'd1);
    check("rst_hrdata", s_hrdata, 32'd0);
    check("rst_m_htrans", 32'(m_htrans), 32'd0);
    check("rst_m_hsel", 32'(m_hsel), 32'd0);
    check("rst_m_haddr", m_haddr, 32'd0);
    check("rst_m_hwrite", 32'(m_hwrite), 32'd0);
    check("rst_no_issue", issued.size(), 32'd0);

    // Cold read, 20 XIP wait cycles: miss, flush, issue, addr, 20 waits, beat.
    do_read(32'h100, d, w);
    check("cold_data", d, 32'hDEAD_BEEF);
    check("cold_wait_cycles", w, 32'd24);
    check("cold_m_haddr", q_at(0), 32'h100);

    // Prefetch fills the 4-word FIFO and then stops.
    wait_cyc(120);
    check("fill_issue_count", issued.size(), 32'd5);
    check("fill_addr1", q_at(1), 32'h104);
    check("fill_addr2", q_at(2), 32'h108);
    check("fill_addr3", q_at(3), 32'h10C);
    check("fill_addr4", q_at(4), 32'h110);

    // Back-to-back sequential hits, one per cycle.
    @(negedge clk);
    s_hsel = 1'b1; s_htrans = 2'b10; s_haddr = 32'h104; s_hwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("burst_ready", 32'(s_hreadyout), 32'd1);
      check("burst_data", s_hrdata, xip_word(32'h104 + 32'(4 * i)));
      if (i < 2) s_haddr = 32'h108 + 32'(4 * i);
      else begin s_hsel = 1'b0; s_htrans = 2'b00; end
    end
    wait_cyc(3);
    check("refill_count", issued.size(), 32'd6);
    check("refill_addr", q_at(5), 32'h114);

    // Branch while the 0x114 fetch is in flight: its data must be discarded.
    xip_wait = 4;
    do_read(32'h400, d, w);
    check("branch_done", 32'(w < 500), 32'd1);
    check("branch_data", d, xip_word(32'h400));
    check("branch_demand_addr", q_at(6), 32'h400);

    // Region boundary: from 0x3F8 only 0x3FC may be prefetched.
    wait_cyc(40);
    mark = issued.size();
    do_read(32'h3F8, d, w);
    check("bound_data", d, xip_word(32'h3F8));
    wait_cyc(40);
    check("bound_issue_count", issued.size(), 32'(mark + 2));
    check("bound_addr0", q_at(mark), 32'h3F8);
    check("bound_addr1", q_at(mark + 1), 32'h3FC);
    do_read(32'h400, d, w);
    check("bound_demand_data", d, xip_word(32'h400));
    check("bound_demand_addr", q_at(mark + 2), 32'h400);

    // Prefetch disabled: two demand fetches only.
    @(negedge clk);
    pf_en = 1'b0;
    wait_cyc(40);
    mark = issued.size();
    do_read(32'h200, d, w);
    check("nopf_data0", d, xip_word(32'h200));
    do_read(32'h204, d, w);
    check("nopf_data1", d, xip_word(32'h204));
    wait_cyc(20);
    check("nopf_issue_count", issued.size(), 32'(mark + 2));
    check("nopf_addr0", q_at(mark), 32'h200);
    check("nopf_addr1", q_at(mark + 1), 32'h204);

    // Write: zero-wait completion, no master activity.
    @(negedge clk);
    s_hsel = 1'b1; s_htrans = 2'b10; s_haddr = 32'h200; s_hwrite = 1'b1;
    @(negedge clk);
    s_hsel = 1'b0; s_htrans = 2'b00; s_hwrite = 1'b0;
    check("write_zero_wait", 32'(s_hreadyout), 32'd1);
    wait_cyc(10);
    check("write_no_issue", issued.size(), 32'(mark + 2));
    check("write_m_htrans", 32'(m_htrans), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
